// File: rtl/matrix_result_fifo.sv
// Result FIFO between the matrix coprocessor and the HPS input PIO.
// The oldest word is held in a head register; the remaining words sit in a circular RAM of DEPTH-1 entries.
module matrix_result_fifo #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     rd_req,
    input  logic                     clr,
    output logic [DATA_W-1:0]        data_out,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RAM_D = DEPTH - 1;

    logic [DATA_W-1:0] mem_q [RAM_D];
    logic [DATA_W-1:0] head_q, head_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic              underflow_q, underflow_d;
    logic              wr_ready_q, wr_ready_d;
    logic              rd_req_q;
    logic              mem_we;
    logic              push, pop;

    // Pointers wrap at DEPTH-1, which is not a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RAM_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push = wr_valid & wr_ready_q;
    assign pop  = rd_req & ~rd_req_q;

    always_comb begin
        head_d      = head_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        underflow_d = underflow_q;
        mem_we      = 1'b0;
        if (clr) begin
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            underflow_d = 1'b0;
        end else if (count_q == '0) begin
            if (pop) underflow_d = 1'b1;
            if (push) begin
                head_d      = wr_data;
                count_d     = CNT_W'(1);
                out_valid_d = 1'b1;
            end
        end else if (count_q == CNT_W'(1)) begin
            // RAM is empty here, so a simultaneous push bypasses straight into the head.
            if (pop && push) begin
                head_d = wr_data;
            end else if (pop) begin
                count_d     = '0;
                out_valid_d = 1'b0;
            end else if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = next_ptr(wr_ptr_q);
                count_d  = count_q + CNT_W'(1);
            end
        end else begin
            if (pop) begin
                head_d   = mem_q[rd_ptr_q];
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
        wr_ready_d = (count_d < CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_req_q    <= 1'b1;
        end else begin
            head_q      <= head_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            underflow_q <= underflow_d;
            wr_ready_q  <= wr_ready_d;
            rd_req_q    <= rd_req;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= wr_data;
    end

    assign data_out  = head_q;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign underflow = underflow_q;
    assign wr_ready  = wr_ready_q;

endmodule

// File: tb/tb_matrix_result_fifo.sv
// Bench for matrix_result_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_matrix_result_fifo;

    localparam int DEPTH  = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset_n;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic              clr;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic [5:0]        count;
    logic              underflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    matrix_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_req    (rd_req),
        .clr       (clr),
        .data_out  (data_out),
        .out_valid (out_valid),
        .count     (count),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue plus the few flags visible to software.
    logic [DATA_W-1:0] mq[$];
    logic [DATA_W-1:0] m_head = '0;
    bit                m_under = 0;
    bit                m_wrdy = 0;
    bit                m_rdq = 1;
    bit                m_push, m_pop;

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_head  = '0;
            m_under = 0;
            m_wrdy  = 0;
            m_rdq   = 1;
        end else begin
            m_push = wr_valid && m_wrdy;
            m_pop  = rd_req && !m_rdq;
            m_rdq  = rd_req;
            if (clr) begin
                mq.delete();
                m_under = 0;
            end else begin
                if (m_pop) begin
                    if (mq.size() == 0) m_under = 1;
                    else void'(mq.pop_front());
                end
                if (m_push) mq.push_back(wr_data);
            end
            if (mq.size() > 0) m_head = mq[0];
            m_wrdy = (mq.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_out",  data_out,  m_head);
            chk("out_valid", out_valid, (mq.size() > 0));
            chk("count",     count,     mq.size());
            chk("underflow", underflow, m_under);
            chk("wr_ready",  wr_ready,  m_wrdy);
        end
    end

    task automatic push(input logic [DATA_W-1:0] w);
        wr_valid = 1'b1;
        wr_data  = w;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic pop();
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        rd_req   = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        clr      = 1'b0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_data_out", data_out, 0);

        // Release with rd_req still high: no pop, no underflow.
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_wr_ready", wr_ready, 1);
        chk("rel_underflow", underflow, 0);
        chk("rel_count", count, 0);
        rd_req = 1'b0;
        @(negedge clk);

        push(32'hA5A5_0001);
        chk("first_word", data_out, 32'hA5A5_0001);
        chk("first_valid", out_valid, 1);
        push(32'hA5A5_0002);
        push(32'hA5A5_0003);
        chk("count3", count, 3);
        pop();
        chk("pop1", data_out, 32'hA5A5_0002);
        pop();
        chk("pop2", data_out, 32'hA5A5_0003);
        pop();
        chk("pop3_valid", out_valid, 0);
        chk("pop3_stale", data_out, 32'hA5A5_0003);

        // Fill to full, then check wrap-around order while draining.
        for (int i = 0; i < DEPTH; i++) push(i);
        chk("full_count", count, 32);
        chk("full_wr_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_data  = 32'h99;
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        chk("full_blocked", count, 32);
        pop();
        chk("full_pop_head", data_out, 1);
        chk("full_pop_ready", wr_ready, 1);
        push(32);
        chk("refill_count", count, 32);
        for (int k = 2; k <= 32; k++) begin
            pop();
            chk("drain_order", data_out, k);
        end
        pop();
        chk("drained", out_valid, 0);

        // count==1: push and pop on the same edge.
        push(32'h10);
        wr_valid = 1'b1;
        wr_data  = 32'h20;
        rd_req   = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        chk("pp1_data", data_out, 32'h20);
        chk("pp1_count", count, 1);
        @(negedge clk);
        pop();

        // Underflow, push+pop while empty, then flush with a dropped push.
        pop();
        chk("uf_set", underflow, 1);
        pop();
        chk("uf_sticky", underflow, 1);
        wr_valid = 1'b1;
        wr_data  = 32'h55;
        rd_req   = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        chk("pp0_data", data_out, 32'h55);
        chk("pp0_count", count, 1);
        chk("pp0_uf", underflow, 1);
        @(negedge clk);
        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'h66;
        @(negedge clk);
        clr      = 1'b0;
        wr_valid = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_uf", underflow, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_data_kept", data_out, 32'h55);
        chk("clr_ready", wr_ready, 1);

        // Reset mid-operation.
        for (int i = 0; i < 5; i++) push(32'h100 + i);
        chk("pre_rst_count", count, 5);
        reset_n  = 1'b0;
        wr_valid = 1'b1;
        @(negedge clk);
        reset_n  = 1'b1;
        wr_valid = 1'b0;
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", wr_ready, 0);
        @(negedge clk);
        push(32'h77);
        chk("post_rst_data", data_out, 32'h77);
        chk("post_rst_count", count, 1);

        // Randomized traffic, alternating drain-heavy and fill-heavy phases.
        for (int i = 0; i < 3000; i++) begin
            bit fill_phase;
            fill_phase = ((i / 500) % 2) == 1;
            wr_valid = ($urandom_range(0, 99) < (fill_phase ? 90 : 30));
            wr_data  = $urandom;
            rd_req   = ($urandom_range(0, 99) < (fill_phase ? 20 : 60));
            clr      = ($urandom_range(0, 255) == 0);
            reset_n  = !($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        reset_n  = 1'b1;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        clr      = 1'b0;
        @(negedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
